// File: rtl/enigma_pkg.sv
// Shared types and constants for the enigma two-port QoS arbiter.
// Beat format, source/state enums and default tuning values live here.
package enigma_pkg;

  localparam int DATA_W   = 128;
  localparam int ID_W     = 5;
  localparam int TAG_W    = ID_W + 1;
  localparam int NUM_TAGS = 1 << TAG_W;

  localparam int AGE_MAX_DEF   = 8;
  localparam int BACKOFF_DEF   = 2;
  localparam int MAX_RETRY_DEF = 15;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // ST_ prefix keeps the literals clear of the BACKOFF parameter name.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_BACKOFF = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] payload;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        qos;
  } beat_t;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/enigma_scoreboard.sv
// Outstanding-tag scoreboard: one busy bit per C-side tag, one set port,
// one clear port, two lookup ports and a flag for releasing a free tag.
module enigma_scoreboard
  import enigma_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set_en,
  input  logic [TAG_W-1:0] i_set_tag,
  input  logic             i_clr_en,
  input  logic [TAG_W-1:0] i_clr_tag,
  input  logic [TAG_W-1:0] i_lk_a_tag,
  input  logic [TAG_W-1:0] i_lk_b_tag,
  output logic             o_lk_a_busy,
  output logic             o_lk_b_busy,
  output logic             o_bad_release
);

  logic [NUM_TAGS-1:0] r_busy;

  // Lookups read the registered bits, so a tag freed this cycle is only
  // visible as free from the next cycle on.
  assign o_lk_a_busy   = r_busy[i_lk_a_tag];
  assign o_lk_b_busy   = r_busy[i_lk_b_tag];
  assign o_bad_release = i_clr_en & ~r_busy[i_clr_tag];

  // NOTE: this bit array is reset like any register; every tag must start
  // free, so it cannot be left to power-up contents like a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (i_clr_en && r_busy[i_clr_tag]) r_busy[i_clr_tag] <= 1'b0;
      if (i_set_en)                      r_busy[i_set_tag] <= 1'b1;
    end
  end

endmodule

// File: rtl/enigma_arb.sv
// Two-port QoS arbiter merging ports A and B onto port C with source tagging,
// tag scoreboarding, age-based starvation relief and conflict backoff/retry.
module enigma_arb
  import enigma_pkg::*;
#(
  parameter int AGE_MAX   = AGE_MAX_DEF,
  parameter int BACKOFF   = BACKOFF_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] payload_a,
  input  logic [ID_W-1:0]   id_a,
  input  logic [1:0]        qos_a,
  input  logic              valid_a,
  output logic              ready_a,
  input  logic [DATA_W-1:0] payload_b,
  input  logic [ID_W-1:0]   id_b,
  input  logic [1:0]        qos_b,
  input  logic              valid_b,
  output logic              ready_b,
  output logic [DATA_W-1:0] payload_c,
  output logic [TAG_W-1:0]  id_c,
  output logic [1:0]        qos_c,
  output logic              valid_c,
  input  logic              ready_c,
  input  logic              conflict_c,
  input  logic              release_c,
  input  logic [TAG_W-1:0]  releaseid_c,
  output logic              error
);

  localparam int AGE_W   = $clog2(AGE_MAX + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int BO_W    = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  localparam logic [AGE_W-1:0]   AGE_LIM   = AGE_W'(AGE_MAX);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_ERR = RETRY_W'(MAX_RETRY);
  localparam logic [BO_W-1:0]    BO_LAST   = BO_W'(BACKOFF - 1);

  state_e             r_state;
  beat_t              r_beat;
  logic               r_valid_c;
  logic               r_error;
  logic [RETRY_W-1:0] r_retry;
  logic [BO_W-1:0]    r_bo_cnt;
  logic [AGE_W-1:0]   r_age_a;
  logic [AGE_W-1:0]   r_age_b;
  src_e               r_rr;

  logic [TAG_W-1:0] w_tag_a;
  logic [TAG_W-1:0] w_tag_b;
  logic             w_busy_a;
  logic             w_busy_b;
  logic             w_elig_a;
  logic             w_elig_b;
  logic             w_hs;
  logic             w_conflict;
  logic             w_loadable;
  logic             w_grant;
  logic             w_tie;
  logic             w_bad_release;
  src_e             w_win;
  beat_t            w_win_beat;

  assign w_tag_a = {1'b0, id_a};
  assign w_tag_b = {1'b1, id_b};

  enigma_scoreboard u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .i_set_en      (w_grant),
    .i_set_tag     (w_win_beat.tag),
    .i_clr_en      (release_c),
    .i_clr_tag     (releaseid_c),
    .i_lk_a_tag    (w_tag_a),
    .i_lk_b_tag    (w_tag_b),
    .o_lk_a_busy   (w_busy_a),
    .o_lk_b_busy   (w_busy_b),
    .o_bad_release (w_bad_release)
  );

  assign w_elig_a = valid_a & ~w_busy_a;
  assign w_elig_b = valid_b & ~w_busy_b;

  // valid_c is only high in SEND, so conflict_c outside a live handshake is ignored.
  assign w_hs       = r_valid_c & ready_c & ~conflict_c;
  assign w_conflict = r_valid_c & ready_c & conflict_c;
  assign w_loadable = (r_state == ST_IDLE) | w_hs;
  assign w_grant    = w_loadable & (w_elig_a | w_elig_b);

  assign ready_a = w_grant & (w_win == SRC_A);
  assign ready_b = w_grant & (w_win == SRC_B);

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and a latch is never inferred.
  always_comb begin
    w_win = SRC_A;
    w_tie = 1'b0;
    if (w_elig_a && !w_elig_b) begin
      w_win = SRC_A;
    end else if (w_elig_b && !w_elig_a) begin
      w_win = SRC_B;
    end else if (w_elig_a && w_elig_b) begin
      if ((r_age_a == AGE_LIM) && (r_age_b != AGE_LIM)) begin
        w_win = SRC_A;
      end else if ((r_age_b == AGE_LIM) && (r_age_a != AGE_LIM)) begin
        w_win = SRC_B;
      end else if (qos_a > qos_b) begin
        w_win = SRC_A;
      end else if (qos_b > qos_a) begin
        w_win = SRC_B;
      end else begin
        w_win = r_rr;
        w_tie = 1'b1;
      end
    end
  end

  always_comb begin
    w_win_beat = '0;
    if (w_win == SRC_A) begin
      w_win_beat.payload = payload_a;
      w_win_beat.tag     = w_tag_a;
      w_win_beat.qos     = qos_a;
    end else begin
      w_win_beat.payload = payload_b;
      w_win_beat.tag     = w_tag_b;
      w_win_beat.qos     = qos_b;
    end
  end

  // An eligible port "loses" only on a cycle where the other port is granted.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age_a <= '0;
      r_age_b <= '0;
      r_rr    <= SRC_A;
    end else begin
      if (!w_elig_a || (w_grant && (w_win == SRC_A))) r_age_a <= '0;
      else if (w_grant && (r_age_a != AGE_LIM))       r_age_a <= r_age_a + 1'b1;

      if (!w_elig_b || (w_grant && (w_win == SRC_B))) r_age_b <= '0;
      else if (w_grant && (r_age_b != AGE_LIM))       r_age_b <= r_age_b + 1'b1;

      if (w_grant && w_tie) r_rr <= other_src(w_win);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_beat    <= '0;
      r_valid_c <= 1'b0;
      r_retry   <= '0;
      r_bo_cnt  <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_bad_release) r_error <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_beat    <= w_win_beat;
            r_valid_c <= 1'b1;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            r_retry <= '0;
            if (w_grant) begin
              r_beat <= w_win_beat;
            end else begin
              r_valid_c <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end else if (w_conflict) begin
            if (r_retry != RETRY_LIM) r_retry <= r_retry + 1'b1;
            if (r_retry >= RETRY_ERR) r_error <= 1'b1;
            if (BACKOFF > 0) begin
              r_valid_c <= 1'b0;
              r_bo_cnt  <= '0;
              r_state   <= ST_BACKOFF;
            end
          end
        end
        ST_BACKOFF: begin
          if (r_bo_cnt == BO_LAST) begin
            r_valid_c <= 1'b1;
            r_state   <= ST_SEND;
          end else begin
            r_bo_cnt <= r_bo_cnt + 1'b1;
          end
        end
        default: begin
          r_valid_c <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign payload_c = r_beat.payload;
  assign id_c      = r_beat.tag;
  assign qos_c     = r_beat.qos;
  assign valid_c   = r_valid_c;
  assign error     = r_error;

endmodule

// File: tb/tb_enigma_arb.sv
// Directed bench for enigma_arb: inputs change 1ns after posedge, outputs are
// compared at negedge against hand-derived expectations.
module tb_enigma_arb;
  import enigma_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] payload_a, payload_b, payload_c;
  logic [ID_W-1:0]   id_a, id_b;
  logic [1:0]        qos_a, qos_b, qos_c;
  logic              valid_a, valid_b, ready_a, ready_b;
  logic [TAG_W-1:0]  id_c, releaseid_c;
  logic              valid_c, ready_c, conflict_c, release_c, error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enigma_arb dut (
    .clk(clk), .rst(rst),
    .payload_a(payload_a), .id_a(id_a), .qos_a(qos_a), .valid_a(valid_a), .ready_a(ready_a),
    .payload_b(payload_b), .id_b(id_b), .qos_b(qos_b), .valid_b(valid_b), .ready_b(ready_b),
    .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c), .valid_c(valid_c), .ready_c(ready_c),
    .conflict_c(conflict_c), .release_c(release_c), .releaseid_c(releaseid_c), .error(error)
  );

  function automatic logic [DATA_W-1:0] pat(input int s, input int k);
    return {8'(s), 88'h0, 32'(k)};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    payload_a = '0; id_a = '0; qos_a = '0; valid_a = 1'b0;
    payload_b = '0; id_b = '0; qos_b = '0; valid_b = 1'b0;
    ready_c = 1'b1; conflict_c = 1'b0; release_c = 1'b0; releaseid_c = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if ({valid_c, id_c, qos_c, error, ready_a, ready_b} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {valid_c, id_c, qos_c, error, ready_a, ready_b});
    end
    total++;
    if (payload_c !== '0) begin
      bad++;
      $display("FAIL reset_payload got=%h exp=0", payload_c);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  // A alone, ids 0..3 back to back: one beat per cycle, one cycle latency.
  task automatic test_a_stream();
    logic exp_v;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      valid_a = (c < 4); id_a = 5'(c); qos_a = 2'd1; payload_a = pat(1, c);
      @(negedge clk);
      exp_v = (c >= 1) && (c <= 4);
      total++;
      if ({ready_a, valid_c} !== {(c < 4), exp_v}) begin
        bad++;
        $display("FAIL t1_ready_valid cyc=%0d got=%b exp=%b", c, {ready_a, valid_c}, {(c < 4), exp_v});
      end
      if (exp_v) begin
        total++;
        if ({id_c, qos_c, payload_c} !== {6'(c - 1), 2'd1, pat(1, c - 1)}) begin
          bad++;
          $display("FAIL t1_beat cyc=%0d got id=%h qos=%0d pl=%h exp id=%h", c, id_c, qos_c, payload_c, 6'(c - 1));
        end
      end
      next_cycle();
    end
  endtask

  // A qos3 beats B qos1 eight times; B's age then forces the ninth slot.
  task automatic test_qos_age();
    int ida;
    logic b_done, prev_v, exp_b;
    logic [TAG_W-1:0] prev_tag;
    do_reset();
    ida = 0; b_done = 1'b0; prev_v = 1'b0; prev_tag = '0;
    for (int c = 0; c < 10; c++) begin
      valid_a = 1'b1; id_a = 5'(ida); qos_a = 2'd3; payload_a = pat(2, ida);
      valid_b = !b_done; id_b = 5'd3; qos_b = 2'd1; payload_b = pat(3, 3);
      @(negedge clk);
      exp_b = (c == 8);
      total++;
      if ({ready_a, ready_b} !== {!exp_b, exp_b}) begin
        bad++;
        $display("FAIL t2_grant cyc=%0d got a=%b b=%b exp a=%b b=%b", c, ready_a, ready_b, !exp_b, exp_b);
      end
      total++;
      if (valid_c !== prev_v || (prev_v && id_c !== prev_tag)) begin
        bad++;
        $display("FAIL t2_id_c cyc=%0d got v=%b id=%h exp v=%b id=%h", c, valid_c, id_c, prev_v, prev_tag);
      end
      prev_v = 1'b1;
      prev_tag = exp_b ? {1'b1, 5'd3} : {1'b0, 5'(ida)};
      if (exp_b) b_done = 1'b1;
      else ida++;
      next_cycle();
    end
  endtask

  // Equal qos: round robin alternates A,B,A,B starting at A.
  task automatic test_rr_tie();
    int ida, idb;
    logic exp_a, prev_v;
    logic [TAG_W-1:0] prev_tag;
    do_reset();
    ida = 0; idb = 0; prev_v = 1'b0; prev_tag = '0;
    for (int c = 0; c < 7; c++) begin
      valid_a = 1'b1; id_a = 5'(ida); qos_a = 2'd2; payload_a = pat(4, ida);
      valid_b = 1'b1; id_b = 5'(idb); qos_b = 2'd2; payload_b = pat(5, idb);
      @(negedge clk);
      exp_a = (c % 2 == 0);
      total++;
      if ({ready_a, ready_b} !== {exp_a, !exp_a}) begin
        bad++;
        $display("FAIL t3_rr cyc=%0d got a=%b b=%b exp a=%b", c, ready_a, ready_b, exp_a);
      end
      total++;
      if (valid_c !== prev_v || (prev_v && id_c !== prev_tag)) begin
        bad++;
        $display("FAIL t3_id_c cyc=%0d got v=%b id=%h exp v=%b id=%h", c, valid_c, id_c, prev_v, prev_tag);
      end
      prev_v = 1'b1;
      prev_tag = exp_a ? {1'b0, 5'(ida)} : {1'b1, 5'(idb)};
      if (exp_a) ida++;
      else idb++;
      next_cycle();
    end
  endtask

  // Reissuing a busy id waits for its release, then goes the cycle after.
  task automatic test_busy_release();
    logic exp_r;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      valid_a = (c < 5); id_a = 5'd5; qos_a = 2'd1; payload_a = pat(6, c);
      release_c = (c == 3); releaseid_c = 6'h05;
      @(negedge clk);
      exp_r = (c == 0) || (c == 4);
      total++;
      if (ready_a !== exp_r) begin
        bad++;
        $display("FAIL t4_ready_a cyc=%0d got=%b exp=%b", c, ready_a, exp_r);
      end
      next_cycle();
    end
    release_c = 1'b0;
    @(negedge clk);
    total++;
    if ({valid_c, id_c, error} !== {1'b0, 6'h05, 1'b0}) begin
      bad++;
      $display("FAIL t4_after got v=%b id=%h err=%b exp v=0 id=05 err=0", valid_c, id_c, error);
    end
  endtask

  // ready_c low holds the beat; conflict_c is ignored while ready_c is low.
  task automatic test_stall();
    logic [TAG_W-1:0] exp_id;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      valid_a = (c < 5); id_a = (c == 0) ? 5'd2 : 5'd3; qos_a = 2'd2;
      payload_a = pat(7, (c == 0) ? 2 : 3);
      ready_c = (c == 0) || (c >= 4);
      conflict_c = (c >= 1) && (c <= 3);
      @(negedge clk);
      exp_id = (c <= 4) ? 6'h02 : 6'h03;
      total++;
      if ({ready_a, valid_c} !== {(c == 0) || (c == 4), (c >= 1) && (c <= 5)}) begin
        bad++;
        $display("FAIL stall_hs cyc=%0d got=%b", c, {ready_a, valid_c});
      end
      if ((c >= 1) && (c <= 5)) begin
        total++;
        if ({id_c, payload_c} !== {exp_id, pat(7, int'(exp_id))}) begin
          bad++;
          $display("FAIL stall_beat cyc=%0d got id=%h exp id=%h", c, id_c, exp_id);
        end
      end
      next_cycle();
    end
  endtask

  // Every offer is rejected: 2-cycle gaps, same beat, error after 16 conflicts.
  task automatic test_conflict_retry();
    int nconf;
    logic exp_v;
    do_reset();
    valid_a = 1'b1; id_a = 5'd1; qos_a = 2'd0; payload_a = pat(8, 1); conflict_c = 1'b1;
    @(negedge clk);
    total++;
    if (ready_a !== 1'b1) begin
      bad++;
      $display("FAIL t5_grant got=%b exp=1", ready_a);
    end
    next_cycle();
    valid_a = 1'b0;
    nconf = 0;
    for (int c = 1; c <= 52; c++) begin
      conflict_c = (c < 49);
      @(negedge clk);
      exp_v = (c <= 49) && ((c - 1) % 3 == 0);
      total++;
      if ({valid_c, error} !== {exp_v, (nconf >= 16)}) begin
        bad++;
        $display("FAIL t5_retry cyc=%0d got v=%b err=%b exp v=%b err=%b", c, valid_c, error, exp_v, (nconf >= 16));
      end
      if (exp_v) begin
        total++;
        if ({id_c, payload_c} !== {6'h01, pat(8, 1)}) begin
          bad++;
          $display("FAIL t5_same_beat cyc=%0d got id=%h pl=%h", c, id_c, payload_c);
        end
        if (conflict_c) nconf++;
      end
      next_cycle();
    end
  endtask

  // Releasing an unissued tag flags error; rst clears it and drops the slot.
  task automatic test_bad_release_rst();
    do_reset();
    release_c = 1'b1; releaseid_c = 6'h21;
    @(negedge clk);
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL t6_err_early got=%b exp=0", error); end
    next_cycle();
    release_c = 1'b0; valid_b = 1'b1; id_b = 5'd1; qos_b = 2'd1; payload_b = pat(9, 1); ready_c = 1'b0;
    @(negedge clk);
    total++;
    if ({error, ready_b} !== 2'b11) begin
      bad++;
      $display("FAIL t6_err_set got err=%b rdy_b=%b exp 1 1", error, ready_b);
    end
    next_cycle();
    valid_b = 1'b0; rst = 1'b1; release_c = 1'b1; releaseid_c = 6'h10;
    @(negedge clk);
    total++;
    if ({valid_c, id_c, error} !== {1'b1, 6'h21, 1'b1}) begin
      bad++;
      $display("FAIL t6_pre_rst got v=%b id=%h err=%b exp 1 21 1", valid_c, id_c, error);
    end
    next_cycle();
    rst = 1'b0; release_c = 1'b0; valid_b = 1'b1; ready_c = 1'b1;
    @(negedge clk);
    total++;
    if ({valid_c, id_c, error, ready_b} !== {1'b0, 6'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL t6_post_rst got v=%b id=%h err=%b rdy_b=%b exp 0 00 0 1", valid_c, id_c, error, ready_b);
    end
    next_cycle();
    valid_b = 1'b0;
    @(negedge clk);
    total++;
    if ({valid_c, id_c, error} !== {1'b1, 6'h21, 1'b0}) begin
      bad++;
      $display("FAIL t6_regrant got v=%b id=%h err=%b exp 1 21 0", valid_c, id_c, error);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_a_stream();
    test_qos_age();
    test_rr_tie();
    test_busy_release();
    test_stall();
    test_conflict_retry();
    test_bad_release_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
